// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and width helpers for the reset sequencer
package reset_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      HOLD      = 3'd4
   } state_e;

   // A single domain still needs a one-bit index register.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer with asynchronous active-low clear
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - lock-filtered, index-ordered release of per-domain resets
// with fault/software re-assertion and a minimum hold time.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NumDomains   = 4,
   parameter int LockFilter   = 16,
   parameter int ReleaseDelay = 8,
   parameter int HoldCycles   = 4,
   parameter int CntWidth     = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_lock,
   input  logic                  i_sw_rst,
   output logic [NumDomains-1:0] o_rst_n,
   output logic                  o_done,
   output logic [STATE_W-1:0]    o_state
);

   localparam int IDX_W = idx_width(NumDomains);

   localparam logic [CntWidth-1:0]   LOCK_LAST = CntWidth'(LockFilter - 1);
   localparam logic [CntWidth-1:0]   REL_LAST  = CntWidth'(ReleaseDelay - 1);
   localparam logic [CntWidth-1:0]   HOLD_LAST = CntWidth'(HoldCycles - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NumDomains - 1);
   localparam logic [NumDomains-1:0] ONE_HOT0  = NumDomains'(1);

   logic lock_s;

   sync_2ff u_lock_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_lock),
      .o_q   (lock_s)
   );

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NumDomains-1:0] rst_n_q, rst_n_d;
   logic                  done_q, done_d;
   logic                  fault;

   assign fault = !lock_s || i_sw_rst;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      done_d  = done_q;

      case (state_q)
         IDLE: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end

         WAIT_LOCK: begin
            if (fault) begin
               cnt_d = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Fault is tested first so it beats a coincident release edge.
         RELEASE: begin
            if (fault) begin
               state_d = HOLD;
               cnt_d   = '0;
               rst_n_d = '0;
               done_d  = 1'b0;
            end else if (cnt_q == REL_LAST) begin
               cnt_d   = '0;
               idx_d   = idx_q + 1'b1;
               rst_n_d = rst_n_q | (ONE_HOT0 << idx_q);
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         RUN: begin
            if (fault) begin
               state_d = HOLD;
               cnt_d   = '0;
               rst_n_d = '0;
               done_d  = 1'b0;
            end
         end

         HOLD: begin
            if (i_sw_rst) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = HOLD;
            cnt_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   assign o_rst_n = rst_n_q;
   assign o_done  = done_q;
   assign o_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - vector table, directed corners and random stimulus for reset_sequencer
module tb_reset_sequencer;

   localparam int LF = 16;
   localparam int RD = 8;
   localparam int HC = 4;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_lock = 1'b0;
   logic       i_sw_rst = 1'b0;
   logic [3:0] rst4;
   logic [0:0] rst1;
   logic       done4, done1;
   logic [2:0] st4, st1;

   int checks = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   reset_sequencer u_dut4 (
      .i_clk(i_clk), .i_rst(i_rst), .i_lock(i_lock), .i_sw_rst(i_sw_rst),
      .o_rst_n(rst4), .o_done(done4), .o_state(st4)
   );

   reset_sequencer #(.NumDomains(1)) u_dut1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_lock(i_lock), .i_sw_rst(i_sw_rst),
      .o_rst_n(rst1), .o_done(done1), .o_state(st1)
   );

   // Behavioural view: run/age/elapsed counts of cycles, release count as elapsed/RD.
   typedef struct {
      int st;
      int run;
      int age;
      int el;
      int rel;
      bit p0;
      bit p1;
   } model_t;

   model_t m4, m1;

   function automatic model_t model_reset();
      model_t r;
      r.st = 0; r.run = 0; r.age = 0; r.el = 0; r.rel = 0; r.p0 = 0; r.p1 = 0;
      return r;
   endfunction

   function automatic model_t model_step(model_t m, int n, bit l, bit sw);
      model_t r;
      bit ls;
      r = m;
      ls = m.p1;
      r.p1 = m.p0;
      r.p0 = l;
      case (m.st)
         0: begin r.st = 1; r.run = 0; end
         1: begin
            if (!ls || sw) r.run = 0;
            else begin
               r.run = m.run + 1;
               if (r.run == LF) begin r.st = 2; r.el = 0; r.rel = 0; r.run = 0; end
            end
         end
         2, 3: begin
            if (!ls || sw) begin r.st = 4; r.age = 0; r.rel = 0; end
            else if (m.st == 2) begin
               r.el = m.el + 1;
               r.rel = r.el / RD;
               if (r.rel == n) r.st = 3;
            end
         end
         default: begin
            if (sw) r.age = 0;
            else begin
               r.age = m.age + 1;
               if (r.age == HC) begin r.st = 1; r.run = 0; end
            end
         end
      endcase
      return r;
   endfunction

   function automatic int exp_rst(model_t m);
      return (1 << m.rel) - 1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      chk("d4_state", int'(st4), m4.st);
      chk("d4_rst_n", int'(rst4), exp_rst(m4));
      chk("d4_done", int'(done4), int'(m4.st == 3));
      chk("d1_state", int'(st1), m1.st);
      chk("d1_rst_n", int'(rst1), exp_rst(m1));
      chk("d1_done", int'(done1), int'(m1.st == 3));
   endtask

   // Starts and ends on a falling edge.
   task automatic cycle(input bit l, input bit sw);
      i_lock = l;
      i_sw_rst = sw;
      @(posedge i_clk);
      m4 = model_step(m4, 4, l, sw);
      m1 = model_step(m1, 1, l, sw);
      @(negedge i_clk);
      check_model();
   endtask

   typedef struct {
      bit lock;
      bit sw;
      int n;
      int st;
      int rst;
      int done;
   } vec_t;

   vec_t vt[$];

   initial begin
      // nominal bring-up
      vt.push_back('{1, 0, 1, 1, 0, 0});
      vt.push_back('{1, 0, 16, 1, 0, 0});
      vt.push_back('{1, 0, 1, 2, 0, 0});
      vt.push_back('{1, 0, 7, 2, 0, 0});
      vt.push_back('{1, 0, 1, 2, 1, 0});
      vt.push_back('{1, 0, 8, 2, 3, 0});
      vt.push_back('{1, 0, 7, 2, 3, 0});
      vt.push_back('{1, 0, 1, 2, 7, 0});
      vt.push_back('{1, 0, 7, 2, 7, 0});
      vt.push_back('{1, 0, 1, 3, 15, 1});
      vt.push_back('{1, 0, 5, 3, 15, 1});
      // software reset in RUN, hold extended by a second pulse
      vt.push_back('{1, 1, 1, 4, 0, 0});
      vt.push_back('{1, 0, 1, 4, 0, 0});
      vt.push_back('{1, 1, 1, 4, 0, 0});
      vt.push_back('{1, 0, 3, 4, 0, 0});
      vt.push_back('{1, 0, 1, 1, 0, 0});
      vt.push_back('{1, 0, 15, 1, 0, 0});
      vt.push_back('{1, 0, 1, 2, 0, 0});
      // lock loss after 0011
      vt.push_back('{1, 0, 16, 2, 3, 0});
      vt.push_back('{0, 0, 2, 2, 3, 0});
      vt.push_back('{0, 0, 1, 4, 0, 0});
      vt.push_back('{0, 0, 3, 4, 0, 0});
      vt.push_back('{0, 0, 1, 1, 0, 0});
      // lock glitch in WAIT_LOCK, then full sequence again
      vt.push_back('{1, 0, 12, 1, 0, 0});
      vt.push_back('{0, 0, 3, 1, 0, 0});
      vt.push_back('{1, 0, 17, 1, 0, 0});
      vt.push_back('{1, 0, 1, 2, 0, 0});
      vt.push_back('{1, 0, 31, 2, 7, 0});
      vt.push_back('{1, 0, 1, 3, 15, 1});
      // final release coinciding with a software reset
      vt.push_back('{1, 1, 1, 4, 0, 0});
      vt.push_back('{1, 0, 3, 4, 0, 0});
      vt.push_back('{1, 0, 1, 1, 0, 0});
      vt.push_back('{1, 0, 15, 1, 0, 0});
      vt.push_back('{1, 0, 1, 2, 0, 0});
      vt.push_back('{1, 0, 31, 2, 7, 0});
      vt.push_back('{1, 1, 1, 4, 0, 0});
      vt.push_back('{1, 0, 3, 4, 0, 0});
      vt.push_back('{1, 0, 1, 1, 0, 0});
      // back to RUN for the asynchronous reset
      vt.push_back('{1, 0, 15, 1, 0, 0});
      vt.push_back('{1, 0, 1, 2, 0, 0});
      vt.push_back('{1, 0, 31, 2, 7, 0});
      vt.push_back('{1, 0, 1, 3, 15, 1});

      i_rst = 1'b0;
      i_lock = 1'b1;
      i_sw_rst = 1'b0;
      m4 = model_reset();
      m1 = model_reset();
      repeat (3) @(negedge i_clk);
      chk("reset_state", int'(st4), 0);
      chk("reset_rst_n", int'(rst4), 0);
      chk("reset_done", int'(done4), 0);
      chk("reset_rst_n_d1", int'(rst1), 0);
      i_rst = 1'b1;

      for (int v = 0; v < vt.size(); v++) begin
         for (int k = 0; k < vt[v].n; k++) cycle(vt[v].lock, vt[v].sw);
         chk($sformatf("vec%0d_state", v), int'(st4), vt[v].st);
         chk($sformatf("vec%0d_rst_n", v), int'(rst4), vt[v].rst);
         chk($sformatf("vec%0d_done", v), int'(done4), vt[v].done);
      end

      // asynchronous reset between clock edges while in RUN
      #2 i_rst = 1'b0;
      #1;
      chk("async_state", int'(st4), 0);
      chk("async_rst_n", int'(rst4), 0);
      chk("async_done", int'(done4), 0);
      chk("async_state_d1", int'(st1), 0);
      chk("async_rst_n_d1", int'(rst1), 0);
      chk("async_done_d1", int'(done1), 0);
      m4 = model_reset();
      m1 = model_reset();
      @(negedge i_clk);
      check_model();
      i_rst = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         cycle($urandom_range(0, 99) >= 4, $urandom_range(0, 99) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
